// File: rtl/retire_unit.sv
// retire_unit: consumer end of the ROB commit interface.
// Takes one retiring instruction per cycle, updates the retirement RAT
// (architectural -> physical map) and hands the displaced physical register
// back to the rename free list through a small valid/ready FIFO. The RRAT is
// the precise-state source that recovery logic reads through rrat_rd_*.
module retire_unit #(
    parameter int ARCH_REGS   = 32,
    parameter int PHYS_REGS   = 64,
    parameter int PC_W        = 32,
    parameter int FREEQ_DEPTH = 4,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid,
    output logic            commit_ready,
    input  logic [AW-1:0]   commit_rd_arch,
    input  logic [PW-1:0]   commit_p_new,
    input  logic [PW-1:0]   commit_p_old,
    input  logic            commit_writes_rd,
    input  logic [PC_W-1:0] commit_pc,
    output logic            free_valid,
    input  logic            free_ready,
    output logic [PW-1:0]   free_preg,
    input  logic [AW-1:0]   rrat_rd_idx,
    output logic [PW-1:0]   rrat_rd_preg,
    output logic [31:0]     retired_count,
    output logic [PC_W-1:0] last_retired_pc
);

    localparam int QW = $clog2(FREEQ_DEPTH);
    localparam int CW = $clog2(FREEQ_DEPTH + 1);

    // Retirement RAT; entry 0 stays at its reset value (x0 is hardwired).
    logic [PW-1:0]   rrat_r [ARCH_REGS];

    // Free-list return FIFO.
    logic [PW-1:0]   fq_mem_r [FREEQ_DEPTH];
    logic [QW-1:0]   fq_head_r;
    logic [QW-1:0]   fq_tail_r;
    logic [CW-1:0]   fq_count_r;

    logic [31:0]     retired_count_r;
    logic [PC_W-1:0] last_pc_r;

    logic            fq_full_s;
    logic            accept_s;
    logic            pop_s;
    logic            upd_s;
    logic [CW-1:0]   fq_count_nxt_s;
    logic [PW-1:0]   rrat_rd_preg_s;

    // Handshake decode; commit_ready depends only on FIFO state and the pop.
    assign fq_full_s    = (fq_count_r == CW'(FREEQ_DEPTH));
    assign free_valid   = (fq_count_r != {CW{1'b0}});
    assign free_preg    = fq_mem_r[fq_head_r];
    assign pop_s        = free_valid && free_ready;
    assign commit_ready = !fq_full_s || pop_s;
    assign accept_s     = commit_valid && commit_ready;
    assign upd_s        = accept_s && commit_writes_rd && (commit_rd_arch != {AW{1'b0}});

    // Next FIFO occupancy: push-only grows, pop-only shrinks, both hold.
    always_comb begin
        fq_count_nxt_s = fq_count_r;
        if (upd_s && !pop_s) begin
            fq_count_nxt_s = fq_count_r + CW'(1);
        end else if (!upd_s && pop_s) begin
            fq_count_nxt_s = fq_count_r - CW'(1);
        end else begin
            fq_count_nxt_s = fq_count_r;
        end
    end

    // Recovery read port: registered state only, x0 always reads as 0.
    always_comb begin
        rrat_rd_preg_s = {PW{1'b0}};
        if (rrat_rd_idx == {AW{1'b0}}) begin
            rrat_rd_preg_s = {PW{1'b0}};
        end else begin
            rrat_rd_preg_s = rrat_r[rrat_rd_idx];
        end
    end

    assign rrat_rd_preg = rrat_rd_preg_s;

    // RRAT update: identity map at reset, new mapping on each writing retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rrat_r[i] <= PW'(i);
            end
        end else if (upd_s) begin
            rrat_r[commit_rd_arch] <= commit_p_new;
        end
    end

    // FIFO storage: the displaced mapping is written at the tail on each update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FREEQ_DEPTH; i++) begin
                fq_mem_r[i] <= {PW{1'b0}};
            end
        end else if (upd_s) begin
            fq_mem_r[fq_tail_r] <= commit_p_old;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq_head_r  <= {QW{1'b0}};
            fq_tail_r  <= {QW{1'b0}};
            fq_count_r <= {CW{1'b0}};
        end else begin
            if (upd_s) begin
                fq_tail_r <= fq_tail_r + QW'(1);
            end
            if (pop_s) begin
                fq_head_r <= fq_head_r + QW'(1);
            end
            fq_count_r <= fq_count_nxt_s;
        end
    end

    // Retirement statistics: every accepted commit counts, writing or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count_r <= 32'd0;
            last_pc_r       <= {PC_W{1'b0}};
        end else if (accept_s) begin
            retired_count_r <= retired_count_r + 32'd1;
            last_pc_r       <= commit_pc;
        end
    end

    assign retired_count   = retired_count_r;
    assign last_retired_pc = last_pc_r;

endmodule

// File: tb/tb_retire_unit.sv
// Directed testbench for retire_unit with hand-computed expected values.
module tb_retire_unit;

    logic        clk;
    logic        rst_n;
    logic        commit_valid;
    logic        commit_ready;
    logic [4:0]  commit_rd_arch;
    logic [5:0]  commit_p_new;
    logic [5:0]  commit_p_old;
    logic        commit_writes_rd;
    logic [31:0] commit_pc;
    logic        free_valid;
    logic        free_ready;
    logic [5:0]  free_preg;
    logic [4:0]  rrat_rd_idx;
    logic [5:0]  rrat_rd_preg;
    logic [31:0] retired_count;
    logic [31:0] last_retired_pc;

    int n_cmp;
    int n_err;

    retire_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .commit_valid     (commit_valid),
        .commit_ready     (commit_ready),
        .commit_rd_arch   (commit_rd_arch),
        .commit_p_new     (commit_p_new),
        .commit_p_old     (commit_p_old),
        .commit_writes_rd (commit_writes_rd),
        .commit_pc        (commit_pc),
        .free_valid       (free_valid),
        .free_ready       (free_ready),
        .free_preg        (free_preg),
        .rrat_rd_idx      (rrat_rd_idx),
        .rrat_rd_preg     (rrat_rd_preg),
        .retired_count    (retired_count),
        .last_retired_pc  (last_retired_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input logic v, input logic [4:0] rd, input logic [5:0] pn,
                              input logic [5:0] po, input logic wr, input logic [31:0] pc);
        commit_valid     = v;
        commit_rd_arch   = rd;
        commit_p_new     = pn;
        commit_p_old     = po;
        commit_writes_rd = wr;
        commit_pc        = pc;
    endtask

    task automatic chk_rrat(input string tag, input logic [4:0] idx, input logic [5:0] exp_v);
        rrat_rd_idx = idx;
        #1;
        chk(tag, 64'(rrat_rd_preg), 64'(exp_v));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        free_ready = 1'b0;
        rrat_rd_idx = 5'd0;
        set_commit(1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 32'h0);

        // Reset release
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk_rrat("rst_rrat5", 5'd5, 6'd5);
        chk_rrat("rst_rrat0", 5'd0, 6'd0);
        chk("rst_free_valid", 64'(free_valid), 64'd0);
        chk("rst_free_preg", 64'(free_preg), 64'd0);
        chk("rst_count", 64'(retired_count), 64'd0);
        chk("rst_pc", 64'(last_retired_pc), 64'd0);
        chk("rst_ready", 64'(commit_ready), 64'd1);

        // Single commit: rd3 -> p40, free p3; write not visible until after the edge
        set_commit(1'b1, 5'd3, 6'd40, 6'd3, 1'b1, 32'h100);
        chk_rrat("pre_rrat3", 5'd3, 6'd3);
        tick();
        commit_valid = 1'b0;
        chk_rrat("single_rrat3", 5'd3, 6'd40);
        chk("single_free_valid", 64'(free_valid), 64'd1);
        chk("single_free_preg", 64'(free_preg), 64'd3);
        chk("single_count", 64'(retired_count), 64'd1);
        chk("single_pc", 64'(last_retired_pc), 64'h100);

        // Non-writing commit, then x0 commit
        set_commit(1'b1, 5'd7, 6'd50, 6'd51, 1'b0, 32'h104);
        tick();
        set_commit(1'b1, 5'd0, 6'd55, 6'd56, 1'b1, 32'h108);
        tick();
        commit_valid = 1'b0;
        chk_rrat("nowr_rrat7", 5'd7, 6'd7);
        chk_rrat("x0_rrat0", 5'd0, 6'd0);
        chk("nowr_free_preg", 64'(free_preg), 64'd3);
        chk("nowr_count", 64'(retired_count), 64'd3);
        chk("nowr_pc", 64'(last_retired_pc), 64'h108);

        // Drain the single queued entry (p3)
        free_ready = 1'b1;
        tick();
        free_ready = 1'b0;
        chk("drain_empty", 64'(free_valid), 64'd0);

        // Backpressure: fill 4 entries 10..13 with free_ready low
        for (int k = 0; k < 4; k++) begin
            set_commit(1'b1, 5'(k + 1), 6'(20 + k), 6'(10 + k), 1'b1, 32'(32'h200 + 4 * k));
            tick();
        end
        set_commit(1'b1, 5'd5, 6'd24, 6'd14, 1'b1, 32'h210);
        #1;
        chk("bp_full_ready", 64'(commit_ready), 64'd0);
        tick();
        chk("bp_held_count", 64'(retired_count), 64'd7);
        chk("bp_held_ready", 64'(commit_ready), 64'd0);
        free_ready = 1'b1;
        #1;
        chk("bp_ready_on_pop", 64'(commit_ready), 64'd1);
        chk("bp_head10", 64'(free_preg), 64'd10);
        tick();
        commit_valid = 1'b0;
        chk("bp_count", 64'(retired_count), 64'd8);
        chk_rrat("bp_rrat5", 5'd5, 6'd24);
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", 64'(free_preg), 64'(11 + k));
            tick();
        end
        chk("bp_drained", 64'(free_valid), 64'd0);

        // Streaming with wrap: each p_old appears one cycle later and pops
        for (int k = 0; k < 20; k++) begin
            set_commit(1'b1, 5'((k % 31) + 1), 6'(k), 6'(30 + k), 1'b1, 32'(32'h300 + 4 * k));
            #1;
            chk("st_ready", 64'(commit_ready), 64'd1);
            tick();
            chk("st_free", 64'({free_valid, free_preg}), 64'({1'b1, 6'(30 + k)}));
        end
        commit_valid = 1'b0;
        tick();
        chk("st_drained", 64'(free_valid), 64'd0);
        chk("st_count", 64'(retired_count), 64'd28);
        chk("st_pc", 64'(last_retired_pc), 64'h34c);

        // Reset during operation with 3 entries queued
        free_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_commit(1'b1, 5'(k + 1), 6'(45 + k), 6'(60 + k), 1'b1, 32'(32'h400 + 4 * k));
            tick();
        end
        commit_valid = 1'b0;
        chk("mr_queued", 64'(free_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_free_valid", 64'(free_valid), 64'd0);
        chk("mr_count", 64'(retired_count), 64'd0);
        chk("mr_pc", 64'(last_retired_pc), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk_rrat("mr_rrat3", 5'd3, 6'd3);
        chk_rrat("mr_rrat1", 5'd1, 6'd1);
        chk("mr_ready", 64'(commit_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
